pulse_gen_multi: RTL and testbench

//  Multi-channel programmable pulse generator, the successor of the fixed 3-cycle start->pulse FSM.

---
 rtl/pulse_gen_multi_pkg.sv | 14 +
 rtl/pulse_gen_multi_if.sv | 25 ++
 rtl/pulse_gen_multi_chan.sv | 81 ++++++++
 rtl/pulse_gen_multi.sv | 34 +++
 tb/tb_pulse_gen_multi.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pulse_gen_multi_pkg.sv
// Shared encodings for the multi-channel pulse generator.
// Per-channel FSM states and the trigger-mode values.
package pulse_gen_pkg;

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_ACTIVE = 2'b01;
   localparam logic [1:0] ST_HOLD   = 2'b10;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RETRIG  = 1'b1;

   localparam int MAX_CHANNELS = 16;

endpackage

// File: rtl/pulse_gen_multi_if.sv
// Control/status bundle between a sequencer (master) and the pulse generator (slave).
// Length field for channel i is len[i*LEN_W +: LEN_W].
interface pulse_gen_multi_if #(
   parameter int CHANNELS = 4,
   parameter int LEN_W    = 8
);
   logic [CHANNELS-1:0]       start;
   logic [CHANNELS*LEN_W-1:0] len;
   logic [CHANNELS-1:0]       mode;
   logic [CHANNELS-1:0]       abort;
   logic [CHANNELS-1:0]       pulse_out;
   logic [CHANNELS-1:0]       busy;
   logic [CHANNELS-1:0]       done;
   logic                      any_active;

   modport master (
      output start, len, mode, abort,
      input  pulse_out, busy, done, any_active
   );

   modport slave (
      input  start, len, mode, abort,
      output pulse_out, busy, done, any_active
   );
endinterface

// File: rtl/pulse_gen_multi_chan.sv
// One pulse channel: IDLE/ACTIVE/HOLD FSM with an LEN_W down-counter.
// Latency 1 cycle from start to pulse; no backpressure, requests outside IDLE/retrigger are dropped.
module pulse_chan
   import pulse_gen_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int HOLDOFF = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             mode,
   input  logic             abort,
   output logic             pulse_out,
   output logic             busy,
   output logic             done
);

   localparam logic [LEN_W-1:0] HOLD_LOAD = LEN_W'(HOLDOFF - 1);

   logic [1:0]       state;
   logic [LEN_W-1:0] cnt;
   logic             mode_q;
   logic             trig_ok;
   logic             retrig;

   assign trig_ok = start && (len != '0);
   // mode is the value latched at the last trigger, not the live input
   assign retrig  = (state == ST_ACTIVE) && (mode_q == MODE_RETRIG) && trig_ok;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         mode_q <= MODE_ONESHOT;
      end else if (abort) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trig_ok) begin
                  state  <= ST_ACTIVE;
                  cnt    <= len - 1'b1;
                  mode_q <= mode;
               end
            end
            ST_ACTIVE: begin
               if (retrig) begin
                  cnt    <= len - 1'b1;
                  mode_q <= mode;
               end else if (cnt == '0) begin
                  if (HOLDOFF > 0) begin
                     state <= ST_HOLD;
                     cnt   <= HOLD_LOAD;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (cnt == '0) state <= ST_IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign pulse_out = (state == ST_ACTIVE);
   assign busy      = (state != ST_IDLE);
   // a retrigger or abort on the final cycle means the pulse did not end here
   assign done      = (state == ST_ACTIVE) && (cnt == '0) && !retrig && !abort;

endmodule

// File: rtl/pulse_gen_multi.sv
// CHANNELS independent pulse channels; start->pulse latency 1 cycle.
// No backpressure: each channel accepts or drops requests according to its own state.
module pulse_gen_multi
   import pulse_gen_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int LEN_W    = 8,
   parameter int HOLDOFF  = 0
) (
   input  logic             clk,
   input  logic             rst,
   pulse_gen_multi_if.slave bus
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      pulse_chan #(
         .LEN_W   (LEN_W),
         .HOLDOFF (HOLDOFF)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .start     (bus.start[i]),
         .len       (bus.len[i*LEN_W +: LEN_W]),
         .mode      (bus.mode[i]),
         .abort     (bus.abort[i]),
         .pulse_out (bus.pulse_out[i]),
         .busy      (bus.busy[i]),
         .done      (bus.done[i])
      );
   end

   assign bus.any_active = |bus.pulse_out;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: one instance without hold-off, one with HOLDOFF=2.
module tb_pulse_gen_multi;
   import pulse_gen_pkg::*;

   localparam int CH = 4;
   localparam int LW = 8;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pulse_gen_multi_if #(.CHANNELS(CH), .LEN_W(LW)) a ();
   pulse_gen_multi_if #(.CHANNELS(CH), .LEN_W(LW)) b ();

   pulse_gen_multi #(.CHANNELS(CH), .LEN_W(LW), .HOLDOFF(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (a)
   );

   pulse_gen_multi #(.CHANNELS(CH), .LEN_W(LW), .HOLDOFF(2)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [CH-1:0] exp_p [1:5];
      logic [CH-1:0] exp_d [1:5];
      logic          hold_p [1:7];
      logic          hold_b [1:7];
      logic          cont_p [1:7];

      rst     = 1'b0;
      a.start = '1;  a.len = '1; a.mode = '0; a.abort = '0;
      b.start = '1;  b.len = '1; b.mode = '0; b.abort = '0;

      // 1. reset held with start asserted
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst_pulse", 32'(a.pulse_out), 32'h0);
         check("rst_busy",  32'(a.busy),      32'h0);
         check("rst_done",  32'(a.done),      32'h0);
         check("rst_any",   32'(a.any_active), 32'h0);
      end
      check("rst_pulse_b", 32'(b.pulse_out), 32'h0);
      a.start = '0; a.len = '0;
      b.start = '0; b.len = '0;
      rst = 1'b1;
      tick();
      check("idle_after_rst", 32'(a.busy), 32'h0);

      // 2. one-shot len=3 on ch0
      a.start[0] = 1'b1; a.len[0*LW +: LW] = 8'd3;
      tick();
      a.start[0] = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         check($sformatf("os_pulse_c%0d", c), 32'(a.pulse_out[0]), 32'(c <= 3));
         check($sformatf("os_done_c%0d", c),  32'(a.done[0]),      32'(c == 3));
         check($sformatf("os_busy_c%0d", c),  32'(a.busy[0]),      32'(c <= 3));
         tick();
      end

      // 3a. retrigger mode on ch1: len 5, restart at edge k+3 with len 4
      a.mode[1] = MODE_RETRIG;
      a.start[1] = 1'b1; a.len[1*LW +: LW] = 8'd5;
      tick();
      a.start[1] = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         check($sformatf("rt_pulse_c%0d", c), 32'(a.pulse_out[1]), 32'(c <= 7));
         check($sformatf("rt_done_c%0d", c),  32'(a.done[1]),      32'(c == 7));
         if (c == 3) begin a.start[1] = 1'b1; a.len[1*LW +: LW] = 8'd4; end
         tick();
         a.start[1] = 1'b0;
      end

      // 3b. same sequence in one-shot mode: second start ignored
      a.mode[1] = MODE_ONESHOT;
      a.start[1] = 1'b1; a.len[1*LW +: LW] = 8'd5;
      tick();
      a.start[1] = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         check($sformatf("nrt_pulse_c%0d", c), 32'(a.pulse_out[1]), 32'(c <= 5));
         check($sformatf("nrt_done_c%0d", c),  32'(a.done[1]),      32'(c == 5));
         if (c == 3) begin a.start[1] = 1'b1; a.len[1*LW +: LW] = 8'd4; end
         tick();
         a.start[1] = 1'b0;
      end

      // 4. HOLDOFF=2 instance, ch2 len=2, start held high
      hold_p = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      hold_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      b.start[2] = 1'b1; b.len[2*LW +: LW] = 8'd2;
      tick();
      for (int c = 1; c <= 7; c++) begin
         check($sformatf("ho_pulse_c%0d", c), 32'(b.pulse_out[2]), 32'(hold_p[c]));
         check($sformatf("ho_busy_c%0d", c),  32'(b.busy[2]),      32'(hold_b[c]));
         tick();
      end
      b.start[2] = 1'b0;

      // 5. abort of a len=10 pulse on ch3 at edge k+4
      a.start[3] = 1'b1; a.len[3*LW +: LW] = 8'd10;
      tick();
      a.start[3] = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         check($sformatf("ab_pulse_c%0d", c), 32'(a.pulse_out[3]), 32'h1);
         check($sformatf("ab_done_c%0d", c),  32'(a.done[3]),      32'h0);
         if (c < 4) tick();
      end
      a.abort[3] = 1'b1;
      tick();
      a.abort[3] = 1'b0;
      check("ab_pulse_after", 32'(a.pulse_out[3]), 32'h0);
      check("ab_busy_after",  32'(a.busy[3]),      32'h0);
      check("ab_done_after",  32'(a.done[3]),      32'h0);

      // len==0 start ignored; abort+start in IDLE stays IDLE
      a.start[3] = 1'b1; a.len[3*LW +: LW] = 8'd0;
      tick();
      check("len0_pulse", 32'(a.pulse_out[3]), 32'h0);
      check("len0_busy",  32'(a.busy[3]),      32'h0);
      a.len[3*LW +: LW] = 8'd4; a.abort[3] = 1'b1;
      tick();
      check("abst_busy", 32'(a.busy[3]), 32'h0);
      a.start[3] = 1'b0; a.abort[3] = 1'b0;

      // 6. all channels at once, len 1..4
      exp_p = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
      exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
      a.mode = '0;
      a.len = {8'd4, 8'd3, 8'd2, 8'd1};
      a.start = '1;
      tick();
      a.start = '0;
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("all_pulse_c%0d", c), 32'(a.pulse_out),  32'(exp_p[c]));
         check($sformatf("all_done_c%0d", c),  32'(a.done),       32'(exp_d[c]));
         check($sformatf("all_any_c%0d", c),   32'(a.any_active), 32'(c <= 4));
         tick();
      end

      // start held, one-shot, no hold-off: one idle cycle between pulses
      cont_p = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      a.start[0] = 1'b1; a.len[0*LW +: LW] = 8'd3;
      tick();
      for (int c = 1; c <= 7; c++) begin
         check($sformatf("cont_pulse_c%0d", c), 32'(a.pulse_out[0]), 32'(cont_p[c]));
         tick();
      end
      a.start[0] = 1'b0;

      // reset mid-pulse: cut with no done
      a.start[2] = 1'b1; a.len[2*LW +: LW] = 8'd6;
      tick();
      a.start[2] = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("rstmid_pulse", 32'(a.pulse_out), 32'h0);
      check("rstmid_done",  32'(a.done),      32'h0);
      tick();
      check("rstmid_busy",  32'(a.busy),      32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
